relu_sched: RTL and testbench
=============================

// Module: relu_sched
//
// PURPOSE
// Time-multiplexes one shared combinational relu stage across N_NEURON neuron
// accumulators in the serial neuron grid. Round-robin arbitration picks a
// pending neuron and drives its split msb/lsb result into the shared relu. The
// block captures the rectified value and hands it downstream on a valid/ready
// stream, tagged with the neuron index. The grant pulse tells the winning
// neuron that its result has been consumed.
//
// PARAMETERS
// N_NEURON  8   number of requesting neurons
// IDX_W     3   index width, clog2(N_NEURON)
// MSB_W     6   width of the msb slice; bit MSB_W-1 is the sign
// LSB_W     12  width of the lsb slice
//
// PORTS
// clk        in   1              system clock, rising edge
// rst        in   1              synchronous reset, active high
// req        in   N_NEURON       req[i]=1: neuron i holds a valid result
// din_msb    in   N_NEURON*MSB_W neuron i msb at [i*MSB_W +: MSB_W]
// din_lsb    in   N_NEURON*LSB_W neuron i lsb at [i*LSB_W +: LSB_W]
// grant      out  N_NEURON       one-hot, 1-cycle pulse: result of neuron i taken
// relu_msb   out  MSB_W          registered operand msb to the shared relu
// relu_lsb   out  LSB_W          registered operand lsb to the shared relu
// relu_dout  in   MSB_W+LSB_W    combinational result from the shared relu
// out_valid  out  1              out_data/out_idx valid
// out_ready  in   1              downstream accepts when out_valid&&out_ready
// out_data   out  MSB_W+LSB_W    rectified result
// out_idx    out  IDX_W          neuron index of out_data
// busy       out  1              1 whenever the FSM is not in IDLE
//
// BEHAVIOUR
// - Reset: on clk edge with rst=1, the state goes to IDLE and every output is
//   0 (grant, relu_msb, relu_lsb, out_valid, out_data, out_idx, busy).
//   The round-robin pointer is last=N_NEURON-1, so neuron 0 wins first.
// - Reset mid-transaction: the transaction is abandoned with no grant and no
//   out_valid. The requester keeps req high and is served again after reset.
// - FSM states: IDLE -> ISSUE -> HOLD -> IDLE.
//   - IDLE: if |req, the winner w is the first set req starting at last+1,
//     wrapping at N_NEURON. Load relu_msb/relu_lsb from slice w, load
//     out_idx<=w and last<=w, then go to ISSUE. If req==0, stay in IDLE.
//   - ISSUE (1 cycle): out_data<=relu_dout, out_valid<=1, grant[w]<=1 for
//     exactly this one edge, then go to HOLD.
//   - HOLD: grant is 0. out_data and out_idx stay stable while out_valid=1.
//     On out_valid&&out_ready: out_valid<=0 and go to IDLE.
//     No re-arbitration happens in the same cycle.
// - Timing: with req sampled high in IDLE at cycle t, out_valid=1 from t+2.
//   Minimum spacing between results is 3 cycles when out_ready is held at 1.
// - Requester contract: req[i] and its slices stay stable from assertion until
//   grant[i] is seen. The requester drops req[i] in the cycle after grant[i].
//   HOLD lasts at least one cycle, so a dropped req is never re-picked.
// - Mid-transaction changes: a req that rises or falls while not in IDLE is
//   ignored until the FSM returns to IDLE. The operand registers are not
//   reloaded.
// - Fairness: when all requests are held high, the winners cycle
//   0,1,...,N-1,0,... in order.
// - Widths: out_data = relu_dout captured as-is. The block does not modify the
//   relu arithmetic (sign set -> 0, sign clear -> pass-through).
//
// TESTING
// - rst held 3 cycles, then released with req=0 -> all outputs 0, busy=0,
//   FSM stays in IDLE.
// - req=8'h04, neuron 2 = {6'h05,12'hABC}, out_ready=1 -> out_valid at t+2,
//   out_data=18'h05ABC, out_idx=2, single grant=8'h04 pulse.
// - req=8'h01, neuron 0 msb=6'h20 (negative) -> out_data=18'h0, out_idx=0,
//   grant=8'h01.
// - req=8'hFF held, each requester re-asserting after its grant ->
//   out_idx sequence 0..7 then 0, with results exactly 3 cycles apart.
// - out_ready=0 for 5 cycles in HOLD -> out_valid, out_data and out_idx stay
//   constant, no new grant; out_ready=1 -> transfer, then IDLE.
// - rst pulsed during ISSUE for a request on neuron 5 -> no grant[5] and no
//   out_valid; after release, neuron 5 is served with out_idx=5.

Source files
------------

// File: rtl/relu_sched_if.sv
// Purpose : result stream between relu_sched and its downstream consumer.
//           Carries the rectified value and the index of the neuron it
//           belongs to under a valid/ready handshake.
// Signals : out_valid  source -> sink  out_data/out_idx valid
//           out_ready  sink -> source  sink accepts when valid && ready
//           out_data   source -> sink  rectified result
//           out_idx    source -> sink  neuron index of out_data
// Modports: master = result source (relu_sched), slave = consumer.
interface relu_sched_if #(
    parameter int DATA_W = 18,
    parameter int IDX_W  = 3
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;

    modport master (
        output out_valid,
        output out_data,
        output out_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_idx,
        output out_ready
    );
endinterface

// File: rtl/relu_sched.sv
// Purpose : shares one combinational relu stage across N_NEURON neuron
//           accumulators. A round-robin arbiter picks a pending neuron, the
//           chosen msb/lsb slices are registered onto the relu operand bus,
//           the rectified value is captured one cycle later and offered on
//           the result stream tagged with the neuron index. A one-cycle
//           grant pulse tells the winner its result has been consumed.
// Ports   : clk, rst      clock and synchronous active-high reset
//           i_req        per-neuron request
//           i_din_msb    neuron i msb at [i*MSB_W +: MSB_W]
//           i_din_lsb    neuron i lsb at [i*LSB_W +: LSB_W]
//           o_grant      one-hot grant pulse
//           o_relu_msb   registered operand msb to the shared relu
//           o_relu_lsb   registered operand lsb to the shared relu
//           i_relu_dout  combinational result from the shared relu
//           out_if       result stream (master side)
//           o_busy       high whenever the FSM is not idle
module relu_sched #(
    parameter int N_NEURON = 8,
    parameter int IDX_W    = 3,
    parameter int MSB_W    = 6,
    parameter int LSB_W    = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_NEURON-1:0]       i_req,
    input  logic [N_NEURON*MSB_W-1:0] i_din_msb,
    input  logic [N_NEURON*LSB_W-1:0] i_din_lsb,
    output logic [N_NEURON-1:0]       o_grant,
    output logic [MSB_W-1:0]          o_relu_msb,
    output logic [LSB_W-1:0]          o_relu_lsb,
    input  logic [MSB_W+LSB_W-1:0]    i_relu_dout,
    relu_sched_if.master              out_if,
    output logic                      o_busy
);
    localparam int DATA_W = MSB_W + LSB_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      r_last;
    logic [N_NEURON-1:0]   r_grant;
    logic [MSB_W-1:0]      r_relu_msb;
    logic [LSB_W-1:0]      r_relu_lsb;
    logic                  r_out_valid;
    logic [DATA_W-1:0]     r_out_data;
    logic [IDX_W-1:0]      r_out_idx;
    logic                  r_busy;

    logic [IDX_W-1:0]      w_last_nxt;
    logic [N_NEURON-1:0]   w_grant_nxt;
    logic [MSB_W-1:0]      w_relu_msb_nxt;
    logic [LSB_W-1:0]      w_relu_lsb_nxt;
    logic                  w_out_valid_nxt;
    logic [DATA_W-1:0]     w_out_data_nxt;
    logic [IDX_W-1:0]      w_out_idx_nxt;

    logic                  w_any;
    logic [IDX_W-1:0]      w_win;
    logic [IDX_W-1:0]      w_cand;

    // Round-robin search: first set request starting just after the last winner.
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_cand = '0;
        for (int k = 1; k <= N_NEURON; k++) begin
            w_cand = IDX_W'((int'(r_last) + k) % N_NEURON);
            if (!w_any && i_req[w_cand]) begin
                w_any = 1'b1;
                w_win = w_cand;
            end else begin
                w_any = w_any;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last      <= IDX_W'(N_NEURON - 1);
            r_grant     <= '0;
            r_relu_msb  <= '0;
            r_relu_lsb  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_grant     <= w_grant_nxt;
            r_relu_msb  <= w_relu_msb_nxt;
            r_relu_lsb  <= w_relu_lsb_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_idx   <= w_out_idx_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_out_valid && out_if.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; grant is a pulse so it defaults low.
    always_comb begin
        w_last_nxt      = r_last;
        w_grant_nxt     = '0;
        w_relu_msb_nxt  = r_relu_msb;
        w_relu_lsb_nxt  = r_relu_lsb;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_idx_nxt   = r_out_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_relu_msb_nxt = i_din_msb[int'(w_win)*MSB_W +: MSB_W];
                    w_relu_lsb_nxt = i_din_lsb[int'(w_win)*LSB_W +: LSB_W];
                    w_out_idx_nxt  = w_win;
                    w_last_nxt     = w_win;
                end else begin
                    w_last_nxt = r_last;
                end
            end
            ST_ISSUE: begin
                // Operands have been stable for a full cycle, so the relu result is settled.
                w_out_data_nxt           = i_relu_dout;
                w_out_valid_nxt          = 1'b1;
                w_grant_nxt[r_out_idx]   = 1'b1;
            end
            ST_HOLD: begin
                if (r_out_valid && out_if.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                end else begin
                    w_out_valid_nxt = r_out_valid;
                end
            end
            default: begin
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    assign o_grant          = r_grant;
    assign o_relu_msb       = r_relu_msb;
    assign o_relu_lsb       = r_relu_lsb;
    assign o_busy           = r_busy;
    assign out_if.out_valid = r_out_valid;
    assign out_if.out_data  = r_out_data;
    assign out_if.out_idx   = r_out_idx;
endmodule

// File: tb/tb_relu_sched.sv
// Directed testbench for relu_sched. Models the shared relu externally and
// checks reset state, single requests, negative clamping, round-robin order
// and spacing, downstream backpressure and reset during a transaction.
module tb_relu_sched;
    localparam int N  = 8;
    localparam int IW = 3;
    localparam int MW = 6;
    localparam int LW = 12;
    localparam int DW = MW + LW;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*MW-1:0] din_msb;
    logic [N*LW-1:0] din_lsb;
    logic [N-1:0]    grant;
    logic [MW-1:0]   relu_msb;
    logic [LW-1:0]   relu_lsb;
    logic [DW-1:0]   relu_dout;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    relu_sched_if #(.DATA_W(DW), .IDX_W(IW)) u_if ();

    relu_sched #(.N_NEURON(N), .IDX_W(IW), .MSB_W(MW), .LSB_W(LW)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (req),
        .i_din_msb   (din_msb),
        .i_din_lsb   (din_lsb),
        .o_grant     (grant),
        .o_relu_msb  (relu_msb),
        .o_relu_lsb  (relu_lsb),
        .i_relu_dout (relu_dout),
        .out_if      (u_if.master),
        .o_busy      (busy)
    );

    // Shared relu stage: negative operand clamps to zero.
    assign relu_dout = relu_msb[MW-1] ? {DW{1'b0}} : {relu_msb, relu_lsb};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_slice(input int i, input logic [MW-1:0] m, input logic [LW-1:0] l);
        din_msb[i*MW +: MW] = m;
        din_lsb[i*LW +: LW] = l;
    endtask

    initial begin
        int n;
        logic [MW-1:0] m;
        logic [LW-1:0] l;

        rst            = 1'b1;
        req            = '0;
        din_msb        = '0;
        din_lsb        = '0;
        u_if.out_ready = 1'b1;

        // Reset held three cycles, released with no requests.
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_relu_msb", 64'(relu_msb), 64'h0);
        chk("rst_relu_lsb", 64'(relu_lsb), 64'h0);
        chk("rst_valid", 64'(u_if.out_valid), 64'h0);
        chk("rst_data", 64'(u_if.out_data), 64'h0);
        chk("rst_idx", 64'(u_if.out_idx), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        tick(); tick();
        chk("idle_busy", 64'(busy), 64'h0);
        chk("idle_valid", 64'(u_if.out_valid), 64'h0);

        // Single positive request on neuron 2.
        set_slice(2, 6'h05, 12'hABC);
        req = 8'h04;
        tick();
        chk("n2_issue_busy", 64'(busy), 64'h1);
        chk("n2_relu_msb", 64'(relu_msb), 64'h05);
        chk("n2_relu_lsb", 64'(relu_lsb), 64'hABC);
        chk("n2_issue_valid", 64'(u_if.out_valid), 64'h0);
        chk("n2_issue_grant", 64'(grant), 64'h0);
        tick();
        chk("n2_valid", 64'(u_if.out_valid), 64'h1);
        chk("n2_data", 64'(u_if.out_data), 64'h05ABC);
        chk("n2_idx", 64'(u_if.out_idx), 64'h2);
        chk("n2_grant", 64'(grant), 64'h04);
        req = 8'h00;
        tick();
        chk("n2_done_valid", 64'(u_if.out_valid), 64'h0);
        chk("n2_done_grant", 64'(grant), 64'h0);
        chk("n2_done_busy", 64'(busy), 64'h0);

        // Negative operand on neuron 0 clamps to zero; pointer wraps from 2 to 0.
        set_slice(0, 6'h20, 12'h123);
        req = 8'h01;
        tick();
        chk("n0_relu_msb", 64'(relu_msb), 64'h20);
        tick();
        chk("n0_valid", 64'(u_if.out_valid), 64'h1);
        chk("n0_data", 64'(u_if.out_data), 64'h0);
        chk("n0_idx", 64'(u_if.out_idx), 64'h0);
        chk("n0_grant", 64'(grant), 64'h01);
        req = 8'h00;
        tick();
        chk("n0_done_valid", 64'(u_if.out_valid), 64'h0);

        // All requests high after a fresh reset: order 0..7 then 0, 3 cycles apart.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            set_slice(i, 6'(i + 1), 12'(i * 273));
        end
        req = 8'hFF;
        for (int k = 0; k <= N; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (u_if.out_valid !== 1'b1 && n < 12);
            m = 6'((k % N) + 1);
            l = 12'((k % N) * 273);
            chk("rr_spacing", 64'(n), (k == 0) ? 64'd2 : 64'd3);
            chk("rr_idx", 64'(u_if.out_idx), 64'(k % N));
            chk("rr_grant", 64'(grant), 64'(8'h01 << (k % N)));
            chk("rr_data", 64'(u_if.out_data), 64'({m, l}));
            if (k == N) begin
                req = 8'h00;
            end
        end
        tick();
        chk("rr_done_valid", 64'(u_if.out_valid), 64'h0);
        chk("rr_done_busy", 64'(busy), 64'h0);

        // Backpressure: out_ready low for five cycles in HOLD.
        set_slice(3, 6'h1F, 12'hFFF);
        u_if.out_ready = 1'b0;
        req = 8'h08;
        tick();
        tick();
        chk("bp_valid", 64'(u_if.out_valid), 64'h1);
        chk("bp_grant", 64'(grant), 64'h08);
        req = 8'h00;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_hold_valid", 64'(u_if.out_valid), 64'h1);
            chk("bp_hold_data", 64'(u_if.out_data), 64'h1FFFF);
            chk("bp_hold_idx", 64'(u_if.out_idx), 64'h3);
            chk("bp_hold_grant", 64'(grant), 64'h0);
            chk("bp_hold_busy", 64'(busy), 64'h1);
        end
        u_if.out_ready = 1'b1;
        tick();
        chk("bp_done_valid", 64'(u_if.out_valid), 64'h0);
        chk("bp_done_busy", 64'(busy), 64'h0);

        // Reset during ISSUE for neuron 5: abandoned, then served after release.
        set_slice(5, 6'h0A, 12'h555);
        req = 8'h20;
        tick();
        chk("rs_issue_busy", 64'(busy), 64'h1);
        rst = 1'b1;
        tick();
        chk("rs_grant", 64'(grant), 64'h0);
        chk("rs_valid", 64'(u_if.out_valid), 64'h0);
        chk("rs_busy", 64'(busy), 64'h0);
        chk("rs_relu_msb", 64'(relu_msb), 64'h0);
        rst = 1'b0;
        tick();
        chk("rs_reissue_grant", 64'(grant), 64'h0);
        chk("rs_reissue_valid", 64'(u_if.out_valid), 64'h0);
        tick();
        chk("rs_valid_after", 64'(u_if.out_valid), 64'h1);
        chk("rs_idx_after", 64'(u_if.out_idx), 64'h5);
        chk("rs_grant_after", 64'(grant), 64'h20);
        chk("rs_data_after", 64'(u_if.out_data), 64'h0A555);
        req = 8'h00;
        tick();
        chk("rs_done_valid", 64'(u_if.out_valid), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
